// File: rtl/hrmf_seq_ctrl.sv
// Sequencer for one HRMF radix-16 engine: frames input beats, drives SEL_HRMF, tracks output valid/last
// across the MTU delay and issues ROTATOR1 twiddle addresses. Option macro: HRMF_CTRL_TF_ROM_REG_EN.
module hrmf_seq_ctrl #(
    parameter int N_PTS   = 64,
    parameter int MTU_LAT = 3,
    parameter int TF_AW   = 6
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             start_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    output logic [1:0]       sel_hrmf_o,
    output logic             out_valid_o,
    output logic             out_last_o,
    output logic [TF_AW-1:0] tf_addr0_o,
    output logic [TF_AW-1:0] tf_addr1_o,
    output logic [TF_AW-1:0] tf_addr2_o,
    output logic [TF_AW-1:0] tf_addr3_o,
    output logic             busy_o,
    output logic             err_o
);

    localparam int BEATS = N_PTS / 4;
    localparam int CW    = $clog2(BEATS);
    localparam int FW    = $clog2(MTU_LAT + 1);
    localparam logic [CW-1:0] LAST_BEAT = CW'(BEATS - 1);

    typedef enum logic [1:0] {ST_IDLE, ST_RUN, ST_FLUSH} state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [FW-1:0]        fl_q, fl_d;
    logic                 err_q, err_d;
    logic [MTU_LAT-1:0]   vld_q, vld_d;
    logic [MTU_LAT-1:0]   lst_q, lst_d;
    logic [CW-1:0]        idx_q [MTU_LAT];
    logic [CW-1:0]        idx_d [MTU_LAT];
    logic                 accept;
    logic                 underrun;
    logic                 last_beat;

    assign accept    = (state_q == ST_RUN) && in_valid_i;
    assign underrun  = (state_q == ST_RUN) && !in_valid_i;
    assign last_beat = (cnt_q == LAST_BEAT);

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fl_d    = fl_q;
        err_d   = err_q;
        case (state_q)
            ST_IDLE: begin
                cnt_d = '0;
                fl_d  = '0;
                if (start_i) begin
                    state_d = ST_RUN;
                    err_d   = 1'b0;
                end
            end
            ST_RUN: begin
                if (!in_valid_i) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                    cnt_d   = '0;
                end else if (last_beat) begin
                    // The counter wraps either way; in FLUSH it keeps feeding SEL_HRMF.
                    cnt_d = '0;
                    if (!start_i) begin
                        state_d = ST_FLUSH;
                        fl_d    = '0;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_FLUSH: begin
                cnt_d = cnt_q + 1'b1;
                if (fl_q == FW'(MTU_LAT - 1)) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else begin
                    fl_d = fl_q + 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // Stage s holds the beat accepted s+1 cycles ago; the last stage is the live output.
    always_comb begin
        vld_d    = '0;
        lst_d    = '0;
        vld_d[0] = accept;
        lst_d[0] = accept && last_beat;
        idx_d[0] = cnt_q;
        for (int s = 1; s < MTU_LAT; s++) begin
            vld_d[s] = vld_q[s-1];
            lst_d[s] = lst_q[s-1];
            idx_d[s] = idx_q[s-1];
        end
        if (underrun) begin
            vld_d = '0;
            lst_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            cnt_q <= '0;
            fl_q  <= '0;
            err_q <= 1'b0;
            vld_q <= '0;
            lst_q <= '0;
            for (int s = 0; s < MTU_LAT; s++) begin
                idx_q[s] <= '0;
            end
        end else begin
            cnt_q <= cnt_d;
            fl_q  <= fl_d;
            err_q <= err_d;
            vld_q <= vld_d;
            lst_q <= lst_d;
            for (int s = 0; s < MTU_LAT; s++) begin
                idx_q[s] <= idx_d[s];
            end
        end
    end

    assign in_ready_o  = (state_q == ST_RUN);
    assign sel_hrmf_o  = (state_q == ST_IDLE) ? 2'b00 : cnt_q[1:0];
    assign out_valid_o = vld_q[MTU_LAT-1];
    assign out_last_o  = lst_q[MTU_LAT-1];
    assign busy_o      = (state_q != ST_IDLE) || (|vld_q);
    assign err_o       = err_q;

    // A registered-output ROM needs its address one stage early (requires MTU_LAT >= 2).
`ifdef HRMF_CTRL_TF_ROM_REG_EN
    localparam int TF_STG = MTU_LAT - 2;
`else
    localparam int TF_STG = MTU_LAT - 1;
`endif

    logic             tf_vld;
    logic [CW-1:0]    tf_j;
    logic [TF_AW-1:0] tf_g;
    logic [1:0]       tf_b;
    logic [TF_AW-1:0] tf_addr [4];

    assign tf_vld = vld_q[TF_STG];
    assign tf_j   = idx_q[TF_STG];
    assign tf_g   = TF_AW'(tf_j >> 2);
    assign tf_b   = tf_j[1:0];

    // Address is g*(4b+k) mod N_PTS; built as shift-and-add over the 4-bit multiplier 4b+k.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            logic [3:0]       mult;
            logic [TF_AW-1:0] prod;

            assign mult = {tf_b, 2'(gi)};

            always_comb begin
                prod = '0;
                for (int p = 0; p < 4; p++) begin
                    if (mult[p]) begin
                        prod = prod + (tf_g << p);
                    end
                end
            end

            assign tf_addr[gi] = tf_vld ? prod : '0;
        end
    endgenerate

    assign tf_addr0_o = tf_addr[0];
    assign tf_addr1_o = tf_addr[1];
    assign tf_addr2_o = tf_addr[2];
    assign tf_addr3_o = tf_addr[3];

endmodule
